// File: rtl/mul_seq_unit.sv
// Sequential radix-2 shift-add multiplier supporting MUL/MULH/MULHSU/MULHU.
// Operand magnitudes are multiplied unsigned; the product sign is applied in
// a single SIGN cycle. busy/valid are registered one stage behind the FSM, so
// busy covers the accept cycle through DONE and valid pulses the cycle after DONE.
module mul_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_a;
  logic             r_neg;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_valid;

  logic             w_sgn1;
  logic             w_sgn2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH:0]   w_sum;
  logic [AW-1:0]    w_step;
  logic [AW-1:0]    w_final;

  // Operand sign/magnitude decode at issue; 2^(WIDTH-1) fits unsigned.
  always_comb begin
    w_sgn1 = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[WIDTH-1];
    w_sgn2 = (op == OP_MULH) && rs2[WIDTH-1];
    w_mag1 = w_sgn1 ? WIDTH'(~rs1 + 1'b1) : rs1;
    w_mag2 = w_sgn2 ? WIDTH'(~rs2 + 1'b1) : rs2;
  end

  // One shift-add step: multiplier bits live in the low half of the accumulator.
  always_comb begin
    w_sum   = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : WIDTH'(0))};
    w_step  = {w_sum, r_acc[WIDTH-1:1]};
    w_final = r_neg ? AW'(~r_acc + 1'b1) : r_acc;
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_neg    <= 1'b0;
      r_op     <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      // A pulse owed by DONE survives a kill in that same cycle.
      r_valid <= (r_state == S_DONE);
      if (kill) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
            if (start) begin
              r_op    <= op;
              r_a     <= w_mag1;
              r_acc   <= {WIDTH'(0), w_mag2};
              r_neg   <= w_sgn1 ^ w_sgn2;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
          S_CALC: begin
            r_acc  <= w_step;
            r_busy <= 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_cnt   <= '0;
              r_state <= S_SIGN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_SIGN: begin
            r_acc    <= w_final;
            r_result <= (r_op == OP_MUL) ? w_final[WIDTH-1:0] : w_final[AW-1:WIDTH];
            r_busy   <= 1'b1;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign valid  = r_valid;
  assign result = r_result;

endmodule
